// File: rtl/am_cic_decimator_if.sv
// Sample-stream interface for the AM detector CIC decimator.
// master: the sample source (drives in/in_valid, receives out/out_valid).
// slave : the decimator itself.
interface am_cic_decimator_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 16
);
   logic signed [IN_W-1:0]  in;
   logic                    in_valid;
   logic signed [OUT_W-1:0] out;
   logic                    out_valid;

   modport master (
      output in,
      output in_valid,
      input  out,
      input  out_valid
   );

   modport slave (
      input  in,
      input  in_valid,
      output out,
      output out_valid
   );
endinterface

// File: rtl/am_cic_decimator.sv
// Decimating CIC filter stage of the AM detector receive path.
// N integrators run at the input sample rate and wrap modulo 2^ACC_W.
// Every R = 2^R_LOG2 valid samples the last integrator is captured and pushed
// through N comb stages, one stage per clock.
// The comb result is normalised by the DC gain R^N with an arithmetic
// right shift, so a DC input appears unchanged at the output.
// out_valid pulses N+1 cycles after the decimation cycle.
// Optional feature macro: FILTER_CHAIN_ROUND_EN
//   defined   -> round half-up before the shift, then saturate to OUT_W
//   undefined -> plain arithmetic-shift truncation (floor)
module am_cic_decimator #(
   parameter int IN_W   = 16,
   parameter int OUT_W  = 16,
   parameter int N      = 3,
   parameter int R_LOG2 = 6
) (
   input logic                aclk,
   input logic                reset,
   am_cic_decimator_if.slave  bus
);

   localparam int ACC_W = IN_W + N * R_LOG2;
   localparam int SH    = ACC_W - OUT_W;

   logic signed [ACC_W-1:0]  in_ext_s;
   logic                     dec_s;
   logic signed [ACC_W-1:0]  comb_x_s [N];

   logic signed [ACC_W-1:0]  integ_r  [N];
   logic [R_LOG2-1:0]        cnt_r;
   logic signed [ACC_W-1:0]  cap_r;
   logic [N:0]               pipe_r;
   logic signed [ACC_W-1:0]  comb_r   [N];
   logic signed [ACC_W-1:0]  dly_r    [N];
   logic signed [OUT_W-1:0]  out_r;
   logic                     out_valid_r;

   // Scales the final comb result down to the output width.
   function automatic logic signed [OUT_W-1:0] scale_out(input logic signed [ACC_W-1:0] v);
`ifdef FILTER_CHAIN_ROUND_EN
      logic signed [ACC_W:0] ext;
      logic signed [ACC_W:0] rnd;
      logic signed [ACC_W:0] sum;
      logic signed [ACC_W:0] shf;
      logic signed [ACC_W:0] sat_hi;
      logic signed [ACC_W:0] sat_lo;
      logic signed [OUT_W-1:0] res;
      // One extra bit of headroom so adding the half-LSB can never wrap.
      ext         = {v[ACC_W-1], v};
      rnd         = {(ACC_W+1){1'b0}};
      rnd[SH-1]   = 1'b1;
      sum         = ext + rnd;
      shf         = sum >>> SH;
      sat_hi      = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
      sat_lo      = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
      if (shf > sat_hi) begin
         res = sat_hi[OUT_W-1:0];
      end else if (shf < sat_lo) begin
         res = sat_lo[OUT_W-1:0];
      end else begin
         res = shf[OUT_W-1:0];
      end
      return res;
`else
      logic signed [ACC_W-1:0] shf;
      shf = v >>> SH;
      return shf[OUT_W-1:0];
`endif
   endfunction

   // Sign-extend the input and flag the decimation cycle.
   always_comb begin
      in_ext_s = {{(ACC_W-IN_W){bus.in[IN_W-1]}}, bus.in};
      if (bus.in_valid && (cnt_r == {R_LOG2{1'b1}})) begin
         dec_s = 1'b1;
      end else begin
         dec_s = 1'b0;
      end
   end

   // Comb stage inputs: stage 0 takes the captured integrator, the rest chain.
   always_comb begin
      comb_x_s[0] = cap_r;
      for (int k = 1; k < N; k++) begin
         comb_x_s[k] = comb_r[k-1];
      end
   end

   // Integrator cascade; each stage adds the pre-update value of the previous one.
   always_ff @(posedge aclk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N; k++) begin
            integ_r[k] <= {ACC_W{1'b0}};
         end
      end else if (bus.in_valid) begin
         integ_r[0] <= integ_r[0] + in_ext_s;
         for (int k = 1; k < N; k++) begin
            integ_r[k] <= integ_r[k] + integ_r[k-1];
         end
      end
   end

   // Decimation counter, advances only on valid samples and wraps R-1 -> 0.
   always_ff @(posedge aclk or negedge reset) begin
      if (!reset) begin
         cnt_r <= {R_LOG2{1'b0}};
      end else if (bus.in_valid) begin
         cnt_r <= cnt_r + R_LOG2'(1);
      end
   end

   // Capture register and comb stages; pipe_r[k] marks stage k input as fresh.
   always_ff @(posedge aclk or negedge reset) begin
      if (!reset) begin
         cap_r  <= {ACC_W{1'b0}};
         pipe_r <= {(N+1){1'b0}};
         for (int k = 0; k < N; k++) begin
            comb_r[k] <= {ACC_W{1'b0}};
            dly_r[k]  <= {ACC_W{1'b0}};
         end
      end else begin
         pipe_r <= {pipe_r[N-1:0], dec_s};
         if (dec_s) begin
            cap_r <= integ_r[N-1];
         end
         for (int k = 0; k < N; k++) begin
            if (pipe_r[k]) begin
               comb_r[k] <= comb_x_s[k] - dly_r[k];
               dly_r[k]  <= comb_x_s[k];
            end
         end
      end
   end

   // Registered output; holds its value between decimated samples.
   always_ff @(posedge aclk or negedge reset) begin
      if (!reset) begin
         out_r       <= {OUT_W{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= pipe_r[N];
         if (pipe_r[N]) begin
            out_r <= scale_out(comb_r[N-1]);
         end
      end
   end

   assign bus.out       = out_r;
   assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_am_cic_decimator.sv
// Self-checking bench for am_cic_decimator (default parameters N=3, R=64).
// The reference model tracks the spec's integrator/comb rules with exact
// 64-bit integers (no wrap) and schedules each expected output N+1 cycles
// after its decimation edge. Directed steady-state constants back it up.
module tb_am_cic_decimator;

   localparam int N      = 3;
   localparam int R      = 64;
   localparam int SH     = 18;
   localparam int LAT    = N + 1;

   logic aclk;
   logic reset;

   am_cic_decimator_if #(.IN_W(16), .OUT_W(16)) bus ();

   am_cic_decimator #(.IN_W(16), .OUT_W(16), .N(N), .R_LOG2(6)) dut (
      .aclk  (aclk),
      .reset (reset),
      .bus   (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   longint integ [N];
   longint prev  [N];
   int     cnt;
   longint cyc;
   longint due_q [$];
   longint val_q [$];
   logic signed [15:0] hold;
   longint last_pulse, prev_pulse, first_pulse;
   bit     want_first;

   function automatic longint scale(input longint c);
      longint s;
`ifdef FILTER_CHAIN_ROUND_EN
      s = (c + (longint'(1) <<< (SH - 1))) >>> SH;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`else
      s = c >>> SH;
`endif
      return s;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin
         integ[k] = 0;
         prev[k]  = 0;
      end
      cnt = 0;
      due_q.delete();
      val_q.delete();
      hold = 16'sd0;
      last_pulse = -1;
      prev_pulse = -1;
   endtask

   task automatic model_edge(input logic v, input logic signed [15:0] x);
      longint c, y;
      if (v) begin
         if (cnt == R - 1) begin
            c = integ[N-1];
            for (int k = 0; k < N; k++) begin
               y = c - prev[k];
               prev[k] = c;
               c = y;
            end
            due_q.push_back(cyc + LAT);
            val_q.push_back(scale(c));
         end
         for (int k = N - 1; k >= 1; k--) integ[k] = integ[k] + integ[k-1];
         integ[0] = integ[0] + longint'(x);
         cnt = (cnt + 1) % R;
      end
   endtask

   task automatic check_cycle();
      logic exp_ov;
      exp_ov = (due_q.size() > 0) && (due_q[0] == cyc);
      total++;
      assert (bus.out_valid === exp_ov) else begin
         bad++;
         $error("FAIL out_valid cyc=%0d: got %b want %b", cyc, bus.out_valid, exp_ov);
      end
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
         hold = 16'(val_q[0]);
         void'(due_q.pop_front());
         void'(val_q.pop_front());
         prev_pulse = last_pulse;
         last_pulse = cyc;
         if (want_first) begin
            first_pulse = cyc;
            want_first  = 1'b0;
         end
      end
      total++;
      assert (bus.out === hold) else begin
         bad++;
         $error("FAIL out cyc=%0d: got %0d want %0d", cyc, bus.out, hold);
      end
   endtask

   // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
   task automatic step(input logic v, input logic signed [15:0] x);
      bus.in_valid = v;
      bus.in       = x;
      @(posedge aclk);
      cyc++;
      model_edge(v, x);
      @(negedge aclk);
      check_cycle();
   endtask

   task automatic check_val(input string tag, input logic signed [15:0] got, input logic signed [15:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic check_num(input string tag, input longint got, input longint want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic check_reset_state(input string tag);
      logic all_zero;
      all_zero = (dut.cnt_r === 6'd0) && (dut.pipe_r === 4'd0) && (dut.cap_r === 34'sd0);
      for (int k = 0; k < N; k++) begin
         if (dut.integ_r[k] !== 34'sd0 || dut.comb_r[k] !== 34'sd0 || dut.dly_r[k] !== 34'sd0)
            all_zero = 1'b0;
      end
      check_val({tag, "_out"}, bus.out, 16'sd0);
      check_num({tag, "_out_valid"}, longint'(bus.out_valid), 0);
      check_num({tag, "_state"}, longint'(all_zero), 1);
   endtask

   initial begin
      logic signed [15:0] x;
      longint rel_cyc;
      cyc        = 0;
      want_first = 1'b0;
      first_pulse = -1;
      model_clear();
      reset        = 1'b0;
      bus.in       = 16'sd0;
      bus.in_valid = 1'b0;
      repeat (3) @(negedge aclk);
      check_reset_state("por");
      reset = 1'b1;

      // DC +1000, continuous valid
      for (int i = 0; i < 8 * R; i++) step(1'b1, 16'sd1000);
      repeat (LAT + 1) step(1'b0, 16'sd0);
      check_val("dc1000_steady", bus.out, 16'sd1000);
      check_num("dc1000_period", last_pulse - prev_pulse, 64);

      // Most negative input
      for (int i = 0; i < 8 * R; i++) step(1'b1, -16'sd32768);
      repeat (LAT + 1) step(1'b0, 16'sd0);
      check_val("neg_full_steady", bus.out, -16'sd32768);

      // Alternating 0,1: window sum is exactly half an output LSB
      for (int i = 0; i < 8 * R; i++) step(1'b1, (i % 2 == 1) ? 16'sd1 : 16'sd0);
      repeat (LAT + 1) step(1'b0, 16'sd0);
`ifdef FILTER_CHAIN_ROUND_EN
      check_val("alt01_steady", bus.out, 16'sd1);
`else
      check_val("alt01_steady", bus.out, 16'sd0);
`endif

      // Valid every third cycle, in = 500
      for (int i = 0; i < 8 * 3 * R; i++) step((i % 3) == 0, 16'sd500);
      repeat (LAT + 1) step(1'b0, 16'sd0);
      check_val("sparse500_steady", bus.out, 16'sd500);
      check_num("sparse500_period", last_pulse - prev_pulse, 192);

      // Random samples with random gaps
      for (int i = 0; i < 1500; i++) begin
         x = 16'($urandom);
         step($urandom_range(0, 3) != 0, x);
      end

      // Continue until a decimation is in flight, then reset before its out_valid
      for (int i = 0; i < 4 * R && due_q.size() == 0; i++) step(1'b1, 16'($urandom));
      check_num("inflight_before_reset", longint'(due_q.size()), 1);
      reset = 1'b0;
      #1;
      check_reset_state("mid");
      repeat (LAT + 2) begin
         @(negedge aclk);
         check_num("no_pulse_in_reset", longint'(bus.out_valid), 0);
      end
      model_clear();
      reset   = 1'b1;
      rel_cyc = cyc;
      want_first = 1'b1;
      for (int i = 0; i < 4 * R; i++) step(1'b1, 16'($urandom));
      repeat (LAT + 1) step(1'b0, 16'sd0);
      check_num("first_pulse_after_reset", first_pulse - rel_cyc, 64 + 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
